mod_k_period_sequencer: RTL and testbench
=========================================

Name: mod_k_period_sequencer

Overview:
- Command-driven controller that sequences a modulo-k cycle counter through a programmed number of k-cycle periods.
- Accepts a command {k, periods} over a valid/ready handshake, then runs the counter and emits a tick at the end of each period.
- Signals completion with a one-cycle done pulse.
- Sits between a host/control FSM and timing-dependent datapath logic, e.g. slot timers and blink/sample schedulers.

Parameters:
N, 8, counter and modulus width in bits
M, 8, period-count width in bits

Ports:
i_clk  input  1  clock, rising-edge
i_reset  input  1  asynchronous, active-high reset
i_valid  input  1  command valid
o_ready  output  1  controller can accept a command
i_k  input  N  modulus k for the command
i_periods  input  M  number of periods P to run
i_abort  input  1  cancel the running command
o_busy  output  1  command in progress (RUN state)
o_count  output  N  current in-period count, 0..k-1
o_tick  output  1  last cycle of a period
o_period  output  M  number of completed periods in the current command
o_done  output  1  one-cycle completion pulse

Behaviour:
- Reset is asynchronous and active-high on i_reset; clock is i_clk.
- Reset values: state=IDLE, o_ready=1, o_busy=0, o_count=0, o_tick=0, o_period=0, o_done=0, latched k_q=0, latched p_q=0.
- FSM states:
  - IDLE: o_ready=1.
  - RUN: o_busy=1.
  - DONE: o_done=1 for exactly one cycle, then IDLE.
- Accept: i_valid && o_ready sampled at a rising edge.
  - Latch k_q=i_k and p_q=i_periods.
  - Clear count and o_period.
  - Next state is RUN, or DONE if i_periods==0.
  - In any state other than IDLE, i_valid is ignored (o_ready=0); the command is not queued.
- RUN:
  - count increments by 1 each cycle.
  - When count==k_q-1 (N-bit wrap arithmetic): o_tick=1 combinationally, count wraps to 0 next cycle, and o_period increments.
  - k=1: o_tick every RUN cycle, and count stays 0.
  - k=0: k_q-1 = all ones, so the period is 2^N cycles.
- Completion: on a tick with o_period==p_q-1, next state is DONE and o_period becomes p_q.
  - RUN lasts exactly k*P cycles.
  - o_done is asserted in cycle k*P+1 after the accept edge.
- DONE: o_count=0, o_tick=0, and o_period holds p_q. Next state is IDLE.
- IDLE:
  - o_count=0 and o_tick=0.
  - o_period holds its last value until the next accept.
- Abort: i_abort in RUN means next state is IDLE, count clears to 0, and there is no o_done pulse.
  - o_period keeps the number of completed periods.
  - Abort coinciding with the final tick: abort wins. o_tick is still 1 that cycle, o_period increments, and o_done is NOT pulsed.
  - i_abort outside RUN has no effect.
- Reset mid-RUN: immediate return to reset values; the latched command is discarded.
- No combinational path from i_valid to o_ready.

Decomposition:
- Package mod_k_seq_pkg:
  - state enum (IDLE, RUN, DONE) as a typedef.
  - Defaults for N and M.
- Sub-module mod_k_counter_en (N-bit):
  - Inputs: i_clk, i_reset, i_clear (synchronous clear), i_en, i_k.
  - Outputs: o_count, o_wrap (count==k-1 while enabled).
  - Instantiated once; the FSM drives i_clear on accept/abort/done and i_en in RUN.
- Period counter and FSM live in the top module.

Test Plan:
- Reset then idle: assert i_reset mid-cycle → all outputs take their reset values immediately, o_ready=1. Hold i_valid=0 for 10 cycles → no tick, o_done=0.
- Nominal run, k=4, P=3:
  - o_tick at RUN cycles 4, 8, 12.
  - o_count sequence 0,1,2,3 repeated.
  - o_period 0→1→2→3.
  - o_done single pulse at cycle 13 after accept.
  - o_ready low throughout, high the cycle after o_done.
- Edge cases:
  - k=1, P=5 → o_tick high for 5 consecutive cycles, then o_done.
  - P=0 (any k) → o_done the cycle after accept, no ticks.
  - k=0, N=4, P=1 → tick after 16 cycles.
- Abort:
  - k=5, P=4, i_abort at RUN cycle 7 → o_period=1, no o_done, o_ready=1 next cycle.
  - Abort on the final tick (cycle 20) → o_period=4, no o_done.
- Handshake and reset:
  - i_valid held high with new values during RUN → ignored; the original run completes unchanged, and a new accept occurs only in IDLE.
  - i_reset at RUN cycle 3 → outputs return to reset values, no o_done.

Source files
------------

// File: rtl/mod_k_seq_pkg.sv
// mod_k_seq_pkg: shared state type and default widths for the mod-k period sequencer
package mod_k_seq_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int N_DEF = 8;
   localparam int M_DEF = 8;
endpackage

// File: rtl/mod_k_counter_en.sv
// mod_k_counter_en: enabled modulo-k counter with sync clear and wrap flag
module mod_k_counter_en import mod_k_seq_pkg::*; #(
   parameter int N = N_DEF
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_clear,
   input  logic         i_en,
   input  logic [N-1:0] i_k,
   output logic [N-1:0] o_count,
   output logic         o_wrap
);
   localparam logic [N-1:0] ONE = 1;
   // k=0 wraps k-1 to all ones, giving a full 2^N period
   assign o_wrap = i_en && (o_count == i_k - ONE);
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) o_count <= '0;
      else if (i_clear) o_count <= '0;
      else if (i_en) o_count <= o_wrap ? '0 : o_count + ONE;
endmodule

// File: rtl/mod_k_period_sequencer.sv
// mod_k_period_sequencer: runs a mod-k counter for P periods per accepted command
module mod_k_period_sequencer import mod_k_seq_pkg::*; #(
   parameter int N = N_DEF,
   parameter int M = M_DEF
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [N-1:0] i_k,
   input  logic [M-1:0] i_periods,
   input  logic         i_abort,
   output logic         o_busy,
   output logic [N-1:0] o_count,
   output logic         o_tick,
   output logic [M-1:0] o_period,
   output logic         o_done
);
   localparam logic [M-1:0] ONE_M = 1;
   state_t       state, state_nx;
   logic [N-1:0] k_q, cnt;
   logic [M-1:0] p_q, period_q;
   logic         accept, last, clr, wrap;
   assign accept = i_valid && (state == IDLE);
   assign last   = wrap && (period_q == p_q - ONE_M);
   assign clr    = accept || (state == RUN && i_abort) || (state == DONE);
   always_comb begin
      state_nx = state;
      if (state == IDLE) begin
         if (accept) state_nx = (i_periods == '0) ? DONE : RUN;
      end else if (state == RUN) begin
         if (i_abort) state_nx = IDLE;
         else if (last) state_nx = DONE;
      end else begin
         state_nx = IDLE;
      end
   end
   mod_k_counter_en #(.N(N)) u_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (clr),
      .i_en    (state == RUN),
      .i_k     (k_q),
      .o_count (cnt),
      .o_wrap  (wrap)
   );
   // period still advances on an aborted final tick
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         state    <= IDLE;
         k_q      <= '0;
         p_q      <= '0;
         period_q <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            k_q      <= i_k;
            p_q      <= i_periods;
            period_q <= '0;
         end else if (wrap) begin
            period_q <= period_q + ONE_M;
         end
      end
   assign o_ready  = state == IDLE;
   assign o_busy   = state == RUN;
   assign o_done   = state == DONE;
   assign o_tick   = wrap;
   assign o_count  = (state == RUN) ? cnt : '0;
   assign o_period = period_q;
endmodule

// File: tb/tb_mod_k_period_sequencer.sv
// tb_mod_k_period_sequencer: directed and random commands checked against an arithmetic model
module tb_mod_k_period_sequencer;
   logic       i_clk, i_reset, i_valid, i_abort;
   logic [3:0] i_k;
   logic [7:0] i_periods;
   logic       o_ready, o_busy, o_tick, o_done;
   logic [3:0] o_count;
   logic [7:0] o_period;
   int tests = 0;
   int fails = 0;

   mod_k_period_sequencer #(.N(4), .M(8)) dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_k       (i_k),
      .i_periods (i_periods),
      .i_abort   (i_abort),
      .o_busy    (o_busy),
      .o_count   (o_count),
      .o_tick    (o_tick),
      .o_period  (o_period),
      .o_done    (o_done)
   );

   initial i_clk = 0;
   always #5 i_clk = ~i_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int rdy, input int bsy, input int cnt,
                          input int tck, input int per, input int dn);
      chk({tag, ".ready"}, 32'(o_ready), 32'(rdy));
      chk({tag, ".busy"}, 32'(o_busy), 32'(bsy));
      chk({tag, ".count"}, 32'(o_count), 32'(cnt));
      chk({tag, ".tick"}, 32'(o_tick), 32'(tck));
      chk({tag, ".period"}, 32'(o_period), 32'(per));
      chk({tag, ".done"}, 32'(o_done), 32'(dn));
   endtask

   // Model: RUN cycle c (1..K*P) has count (c-1)%K, tick when c%K==0, period (c-1)/K
   task automatic run_cmd(input int k, input int p, input int abort_at, input int rst_at, input bit noise);
      int kk = (k == 0) ? 16 : k;
      int total = kk * p;
      bit stopped = 0;
      chk("pre.ready", 32'(o_ready), 1);
      i_valid = 1;
      i_k = 4'(k);
      i_periods = 8'(p);
      @(negedge i_clk);
      i_valid = 0;
      for (int c = 1; c <= total; c++) begin
         if (noise) begin
            i_valid = 1;
            i_k = 4'($urandom_range(0, 15));
            i_periods = 8'($urandom_range(0, 255));
         end
         chk_all("run", 0, 1, (c - 1) % kk, int'(c % kk == 0), (c - 1) / kk, 0);
         if (c == total || c == abort_at || c == rst_at) i_valid = 0;
         if (c == rst_at) begin
            #2 i_reset = 1;
            #1 chk_all("rst_mid", 1, 0, 0, 0, 0, 0);
            @(negedge i_clk);
            i_reset = 0;
            chk_all("rst_after", 1, 0, 0, 0, 0, 0);
            stopped = 1;
            break;
         end
         if (c == abort_at) begin
            i_abort = 1;
            @(negedge i_clk);
            i_abort = 0;
            chk_all("abort", 1, 0, 0, 0, c / kk, 0);
            @(negedge i_clk);
            chk_all("abort_idle", 1, 0, 0, 0, c / kk, 0);
            stopped = 1;
            break;
         end
         @(negedge i_clk);
      end
      if (!stopped) begin
         i_valid = 0;
         chk_all("done", 0, 0, 0, 0, p, 1);
         @(negedge i_clk);
         chk_all("idle", 1, 0, 0, 0, p, 0);
      end
   endtask

   initial begin
      i_reset = 0;
      i_valid = 0;
      i_abort = 0;
      i_k = 0;
      i_periods = 0;
      #3 i_reset = 1;
      #1 chk_all("reset", 1, 0, 0, 0, 0, 0);
      @(negedge i_clk);
      i_reset = 0;
      for (int i = 0; i < 10; i++) begin
         i_abort = (i == 4);
         chk_all("idle0", 1, 0, 0, 0, 0, 0);
         @(negedge i_clk);
      end
      i_abort = 0;
      run_cmd(4, 3, 0, 0, 0);
      run_cmd(1, 5, 0, 0, 0);
      run_cmd(7, 0, 0, 0, 0);
      run_cmd(0, 1, 0, 0, 0);
      run_cmd(5, 4, 7, 0, 0);
      run_cmd(5, 4, 20, 0, 0);
      run_cmd(4, 3, 0, 0, 1);
      run_cmd(3, 2, 0, 0, 0);
      run_cmd(4, 3, 0, 3, 0);
      run_cmd(2, 2, 0, 0, 0);
      for (int n = 0; n < 12; n++) begin
         int k = $urandom_range(0, 15);
         int p = $urandom_range(0, 5);
         int tot = ((k == 0) ? 16 : k) * p;
         int ab = ($urandom_range(0, 2) == 0 && tot > 0) ? $urandom_range(1, tot) : 0;
         run_cmd(k, p, ab, 0, bit'($urandom_range(0, 1)));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
